// File: rtl/axum_ctx_copier_if.sv
// Register-file map window bus: one request per cycle, responder always accepts,
// response (rvalid/rdata/err) arrives some cycles later.
interface axum_ctx_copier_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic                     req;
  logic [AddressWidth-1:0]  addr;
  logic                     we;
  logic [DataWidth/8-1:0]   be;
  logic [DataWidth-1:0]     wdata;
  logic                     rvalid;
  logic [DataWidth-1:0]     rdata;
  logic                     err;

  modport master (
    output req, addr, we, be, wdata,
    input  rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output rvalid, rdata, err
  );
endinterface

// File: rtl/axum_ctx_copier.sv
// Copies x1..x31 of one register-file context to another over the map window,
// one access outstanding at a time, reporting ok / bus error / timeout / abort.
module axum_ctx_copier #(
  parameter int                      AddressWidth  = 32,
  parameter int                      DataWidth     = 32,
  parameter logic [AddressWidth-1:0] BaseAddr      = {AddressWidth{1'b0}},
  parameter int                      TimeoutCycles = 16,
  parameter int                      NrCtx         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [$clog2(NrCtx)-1:0]   src_ctx_i,
  input  logic [$clog2(NrCtx)-1:0]   dst_ctx_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [1:0]                 status_o,
  axum_ctx_copier_if.master          map
);

  localparam int CtxW = $clog2(NrCtx);
  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN} state_t;

  state_t                    state_r, state_n;
  logic [4:0]                idx_r, idx_n;
  logic [CtxW-1:0]           src_r, src_n, dst_r, dst_n;
  logic [CntW-1:0]           cnt_r, cnt_n;
  logic                      abort_r, abort_n, abort_s;
  logic [1:0]                status_r, status_n;
  logic [DataWidth-1:0]      data_r, data_n;
  logic                      req_r, req_n, we_r, we_n, busy_r, busy_n, done_r, done_n;
  logic [DataWidth/8-1:0]    be_r, be_n;
  logic [AddressWidth-1:0]   addr_r, addr_n;
  logic                      timeout_s;

  // Register-file window layout: context in bits [8:7], register in bits [6:2].
  function automatic logic [AddressWidth-1:0] addr_of(input logic [CtxW-1:0] ctx,
                                                      input logic [4:0] idx);
    return BaseAddr | AddressWidth'({ctx, idx, 2'b00});
  endfunction

  assign abort_s   = abort_r | abort_i;
  assign timeout_s = (cnt_r == CntW'(TimeoutCycles - 1));

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_n  = state_r;
    idx_n    = idx_r;
    src_n    = src_r;
    dst_n    = dst_r;
    cnt_n    = cnt_r;
    abort_n  = abort_s;
    status_n = status_r;
    data_n   = data_r;
    case (state_r)
      IDLE: begin
        abort_n = 1'b0;
        if (start_i) begin
          if (src_ctx_i == dst_ctx_i) begin
            status_n = 2'd3;
            state_n  = FIN;
          end else begin
            src_n    = src_ctx_i;
            dst_n    = dst_ctx_i;
            idx_n    = 5'd1;
            status_n = 2'd0;
            state_n  = RD_REQ;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RD_REQ: begin
        cnt_n   = {CntW{1'b0}};
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (map.rvalid) begin
          if (map.err) begin
            status_n = 2'd1;
            state_n  = FIN;
          end else begin
            data_n = map.rdata;
            if (abort_s) begin
              status_n = 2'd3;
              state_n  = FIN;
            end else begin
              state_n = WR_REQ;
            end
          end
        end else if (timeout_s) begin
          status_n = 2'd2;
          state_n  = FIN;
        end else begin
          cnt_n = cnt_r + CntW'(1);
        end
      end
      WR_REQ: begin
        cnt_n   = {CntW{1'b0}};
        state_n = WR_WAIT;
      end
      WR_WAIT: begin
        if (map.rvalid) begin
          if (map.err) begin
            status_n = 2'd1;
            state_n  = FIN;
          end else if (idx_r == 5'd31) begin
            status_n = 2'd0;
            state_n  = FIN;
          end else if (abort_s) begin
            status_n = 2'd3;
            state_n  = FIN;
          end else begin
            idx_n   = idx_r + 5'd1;
            state_n = RD_REQ;
          end
        end else if (timeout_s) begin
          status_n = 2'd2;
          state_n  = FIN;
        end else begin
          cnt_n = cnt_r + CntW'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    req_n  = (state_n == RD_REQ) || (state_n == WR_REQ);
    we_n   = (state_n == WR_REQ);
    be_n   = {(DataWidth/8){we_n}};
    busy_n = (state_n != IDLE);
    done_n = (state_n == FIN);
    if (state_n == RD_REQ) begin
      addr_n = addr_of(src_n, idx_n);
    end else if (state_n == WR_REQ) begin
      addr_n = addr_of(dst_n, idx_n);
    end else begin
      addr_n = {AddressWidth{1'b0}};
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      idx_r    <= 5'd1;
      src_r    <= {CtxW{1'b0}};
      dst_r    <= {CtxW{1'b0}};
      cnt_r    <= {CntW{1'b0}};
      abort_r  <= 1'b0;
      status_r <= 2'd0;
      data_r   <= {DataWidth{1'b0}};
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      be_r     <= {(DataWidth/8){1'b0}};
      addr_r   <= {AddressWidth{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      idx_r    <= idx_n;
      src_r    <= src_n;
      dst_r    <= dst_n;
      cnt_r    <= cnt_n;
      abort_r  <= abort_n;
      status_r <= status_n;
      data_r   <= data_n;
      req_r    <= req_n;
      we_r     <= we_n;
      be_r     <= be_n;
      addr_r   <= addr_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign status_o  = status_r;
  assign map.req   = req_r;
  assign map.we    = we_r;
  assign map.be    = be_r;
  assign map.addr  = addr_r;
  assign map.wdata = data_r;

endmodule

// File: tb/tb_axum_ctx_copier.sv
// Scoreboard bench: directed copies against a 1-cycle register-file responder;
// expected bus accesses and completions are queued and checked by a monitor.
module tb_axum_ctx_copier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] src_ctx, dst_ctx;
  logic       busy, done;
  logic [1:0] status;

  axum_ctx_copier_if #(.AddressWidth(32), .DataWidth(32)) map ();

  axum_ctx_copier #(
    .AddressWidth(32), .DataWidth(32), .BaseAddr(32'h0),
    .TimeoutCycles(16), .NrCtx(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .src_ctx_i(src_ctx), .dst_ctx_i(dst_ctx),
    .busy_o(busy), .done_o(done), .status_o(status),
    .map(map)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { logic [1:0] st; int lat; } done_t;
  acc_t  req_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [31:0] mem [4][32];
  int err_rd_reg  = -1;
  int hold_wr_reg = -1;
  int late_cnt    = 0;
  logic        p_valid = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] orig(input int c, input int r);
    logic [31:0] v;
    v = (c == 1) ? (32'hA500_0000 | 32'(r)) : (32'h5A00_0000 | 32'(c << 8) | 32'(r));
    return v;
  endfunction

  task automatic init_mem();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 32; r++)
        mem[c][r] = orig(c, r);
  endtask

  task automatic push_rd(input int s, input int r);
    acc_t a;
    a.we = 1'b0; a.addr = 32'((s << 7) | (r << 2)); a.wdata = 32'h0;
    req_q.push_back(a);
  endtask

  task automatic push_wr(input int d, input int r, input logic [31:0] w);
    acc_t a;
    a.we = 1'b1; a.addr = 32'((d << 7) | (r << 2)); a.wdata = w;
    req_q.push_back(a);
  endtask

  task automatic push_rw(input int s, input int d, input int first, input int last);
    for (int r = first; r <= last; r++) begin
      push_rd(s, r);
      push_wr(d, r, 32'hA500_0000 | 32'(r));
    end
  endtask

  task automatic push_done(input logic [1:0] st, input int lat);
    done_t e;
    e.st = st; e.lat = lat;
    done_q.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] s, input logic [1:0] d);
    @(negedge clk);
    start = 1'b1; src_ctx = s; dst_ctx = d;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
    end
  endtask

  always @(posedge clk) cyc++;

  // Responder: answers the previous cycle's request one cycle later.
  always @(posedge clk) begin
    int c, r;
    #1;
    map.rvalid = 1'b0; map.err = 1'b0; map.rdata = 32'h0;
    if (rst) begin
      p_valid  = 1'b0;
      late_cnt = 0;
    end else begin
      if (late_cnt > 0) begin
        late_cnt--;
        if (late_cnt == 0) begin
          map.rvalid = 1'b1; map.rdata = 32'hDEAD_BEEF;
        end
      end
      if (p_valid) begin
        c = int'(p_addr[8:7]); r = int'(p_addr[6:2]);
        if (p_we && r == hold_wr_reg) begin
          late_cnt = 20;
        end else begin
          map.rvalid = 1'b1;
          if (!p_we && r == err_rd_reg) map.err = 1'b1;
          else if (p_we) mem[c][r] = p_wdata;
          else map.rdata = mem[c][r];
        end
      end
      p_valid = map.req; p_we = map.we; p_addr = map.addr; p_wdata = map.wdata;
    end
  end

  // Monitor: compares every bus request and completion against the queues.
  always @(negedge clk) begin
    acc_t  a;
    done_t e;
    if (!rst) begin
      if (map.req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=addr_%0h required=no_request", map.addr);
        end else begin
          a = req_q.pop_front();
          check("req_we", map.we, a.we);
          check("req_addr", map.addr, a.addr);
          check("req_be", map.be, a.we ? 4'hF : 4'h0);
          if (a.we) check("req_wdata", map.wdata, a.wdata);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=status_%0d required=no_done", status);
        end else begin
          e = done_q.pop_front();
          check("done_status", status, e.st);
          check("done_latency", cyc - start_cyc + 1, e.lat);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_ctx = 2'd0; dst_ctx = 2'd0;
    init_mem();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_req", map.req, 0);
    check("rst_addr_we_be", {map.addr, map.we, map.be}, 0);
    check("rst_wdata", map.wdata, 0);
    rst = 1'b0;

    // Full copy 1 -> 2.
    push_rw(1, 2, 1, 31);
    push_done(2'd0, 126);
    do_start(2'd1, 2'd2);
    check("full_busy", busy, 1);
    wait_done(200);
    @(negedge clk);
    check("full_status_held", status, 0);
    check("full_idle", busy, 0);
    check("full_req_left", req_q.size(), 0);
    for (int r = 1; r < 32; r++) check("full_dst", mem[2][r], 32'hA500_0000 | 32'(r));
    check("full_x0_untouched", mem[2][0], 32'h5A00_0200);

    // Bus error on the read of x7.
    init_mem();
    err_rd_reg = 7;
    push_rw(1, 2, 1, 6);
    push_rd(1, 7);
    push_done(2'd1, 28);
    do_start(2'd1, 2'd2);
    wait_done(100);
    err_rd_reg = -1;
    repeat (3) @(negedge clk);
    check("err_req_left", req_q.size(), 0);
    check("err_x6_copied", mem[2][6], 32'hA500_0006);
    for (int r = 7; r < 32; r++) check("err_dst_kept", mem[2][r], 32'h5A00_0200 | 32'(r));

    // Write of x3 never answered: timeout, then a late rvalid arrives.
    init_mem();
    hold_wr_reg = 3;
    push_rw(1, 2, 1, 2);
    push_rd(1, 3);
    push_wr(2, 3, 32'hA500_0003);
    push_done(2'd2, 29);
    do_start(2'd1, 2'd2);
    wait_done(100);
    repeat (30) @(negedge clk);
    hold_wr_reg = -1;
    check("to_idle_after_late", busy, 0);
    check("to_status_held", status, 2);
    check("to_req_left", req_q.size(), 0);
    check("to_done_left", done_q.size(), 0);
    check("to_x3_kept", mem[2][3], 32'h5A00_0203);

    // Abort during the read wait of x5.
    init_mem();
    push_rw(1, 2, 1, 4);
    push_rd(1, 5);
    push_done(2'd3, 20);
    do_start(2'd1, 2'd2);
    repeat (17) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(100);
    repeat (3) @(negedge clk);
    check("abort_req_left", req_q.size(), 0);
    check("abort_x4_copied", mem[2][4], 32'hA500_0004);
    check("abort_x5_kept", mem[2][5], 32'h5A00_0205);

    // Same source and destination: illegal.
    push_done(2'd3, 2);
    do_start(2'd3, 2'd3);
    wait_done(10);
    repeat (3) @(negedge clk);
    check("same_done_left", done_q.size(), 0);
    check("same_idle", busy, 0);

    // Reset mid-copy, then a fresh copy.
    init_mem();
    push_rw(1, 2, 1, 31);
    do_start(2'd1, 2'd2);
    repeat (10) @(negedge clk);
    check("pre_rst_req", map.req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", map.req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_we_be_addr", {map.addr, map.we, map.be}, 0);
    check("async_rst_done_status", {done, status}, 0);
    @(negedge clk);
    req_q.delete();
    rst = 1'b0;
    init_mem();
    push_rw(1, 2, 1, 31);
    push_done(2'd0, 126);
    do_start(2'd1, 2'd2);
    wait_done(200);
    repeat (3) @(negedge clk);
    check("rerun_req_left", req_q.size(), 0);
    check("rerun_x1", mem[2][1], 32'hA500_0001);
    check("rerun_x31", mem[2][31], 32'hA500_001F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
